// File: rtl/fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch stage.
// Imported by fetch_unit and its next-pc mux.
package fetch_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Word addresses wrap modulo 2**ADDR_W.
  function automatic addr_t addr_inc(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-pc priority mux (rst > halt > redirect > stall > increment) and imem address select.
// Purely combinational; a stall re-reads the instruction currently being presented.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic              rst_i,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic [ADDR_W-1:0] fetch_pc_i,
  input  logic [ADDR_W-1:0] data_pc_i,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic [ADDR_W-1:0] data_pc_o,
  output logic [ADDR_W-1:0] imem_addr_o
);

  always_comb begin
    fetch_pc_o  = addr_inc(fetch_pc_i);
    data_pc_o   = fetch_pc_i;
    imem_addr_o = fetch_pc_i;
    if (rst_i) begin
      fetch_pc_o  = '0;
      data_pc_o   = '0;
      imem_addr_o = '0;
    end else if (halt_i) begin
      fetch_pc_o  = fetch_pc_i;
      data_pc_o   = data_pc_i;
      imem_addr_o = fetch_pc_i;
    end else if (redirect_i) begin
      // Target is read this cycle so its data lands with the next edge.
      fetch_pc_o  = addr_inc(redirect_addr_i);
      data_pc_o   = redirect_addr_i;
      imem_addr_o = redirect_addr_i;
    end else if (stall_i) begin
      fetch_pc_o  = fetch_pc_i;
      data_pc_o   = data_pc_i;
      imem_addr_o = data_pc_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives a synchronous-read imem, presents instr/pc to decode one cycle later.
// Stall holds the presented instruction, redirect squashes it, halt stops fetch until reset.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic               if_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] data_pc_q, data_pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic halt_eff, redirect_eff, stall_eff;
  logic accept;

  // Controls are only honoured in RUN; HALT looks like a permanent halt, BOOT like a plain step.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    halt_eff     = 1'b0;
    redirect_eff = 1'b0;
    stall_eff    = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: begin
        halt_eff     = halt;
        redirect_eff = redirect;
        stall_eff    = stall;
        if (halt) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (redirect || !stall) begin
          valid_d = 1'b1;
        end
      end
      HALT: begin
        halt_eff = 1'b1;
        valid_d  = 1'b0;
      end
      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  fetch_next_pc u_next_pc (
    .rst_i           (rst),
    .halt_i          (halt_eff),
    .redirect_i      (redirect_eff),
    .stall_i         (stall_eff),
    .redirect_addr_i (redirect_addr),
    .fetch_pc_i      (fetch_pc_q),
    .data_pc_i       (data_pc_q),
    .fetch_pc_o      (fetch_pc_d),
    .data_pc_o       (data_pc_d),
    .imem_addr_o     (imem_addr)
  );

  assign if_valid    = (state_q == RUN) && valid_q;
  assign if_instr    = if_valid ? imem_instr : NOP_INSTR;
  assign if_pc       = data_pc_q;
  assign if_pc_plus1 = addr_inc(data_pc_q);
  assign fetch_count = count_q;

  assign accept  = if_valid && !stall && !redirect;
  assign count_d = accept ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= '0;
      data_pc_q  <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      data_pc_q  <= data_pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-002 The port rst SHALL be an input, 1 bit wide; reset is synchronous and active-high.
REQ-003 The port stall SHALL be an input, 1 bit wide; when high, decode cannot accept the current fetch output.
REQ-004 The port redirect SHALL be an input, 1 bit wide; when high, a branch, jump, jal or jr has resolved as taken.
REQ-005 The port redirect_addr SHALL be an input, 10 bits wide, and carries the word address of the redirect target.
REQ-006 The port halt SHALL be an input, 1 bit wide; when high, decode has seen a halt and fetch stops.
REQ-007 The port imem_addr SHALL be an output, 10 bits wide, and carries the word address to the synchronous-read instruction memory.
REQ-008 The port imem_instr SHALL be an input, 32 bits wide, and carries instruction memory read data, valid one clk after its address.
REQ-009 The port if_instr SHALL be an output, 32 bits wide, and carries the fetched instruction to decode.
REQ-010 The port if_pc SHALL be an output, 10 bits wide, and carries the word address of if_instr.
REQ-011 The port if_pc_plus1 SHALL be an output, 10 bits wide, and carries if_pc+1 (the jal link value).
REQ-012 The port if_valid SHALL be an output, 1 bit wide, and is high when if_instr/if_pc are a real instruction.
REQ-013 The port fetch_count SHALL be an output, 16 bits wide, and counts instructions accepted by decode.

Function
REQ-014 State: pc_q (10 b, next address to read), pc_d (10 b, address whose data is on imem_instr), valid_q, fsm state in {BOOT, RUN, HALT}, fetch_count.
REQ-015 Next-pc priority SHALL be rst > halt > redirect > stall > pc_q+1.
REQ-016 imem_addr SHALL be 0 during rst, pc_d when stall=1 and redirect=0, else pc_q (combinational), so a stalled instruction is re-read unchanged.
REQ-017 Each non-stalled RUN edge: pc_d<=pc_q, pc_q<=pc_q+1, valid_q<=1; latency from imem_addr to if_valid is exactly 1 cycle.
REQ-018 Stall (no redirect): pc_q, pc_d, valid_q and if_instr SHALL all hold.
REQ-019 Redirect: pc_q<=redirect_addr+1, pc_d<=redirect_addr, imem_addr=redirect_addr that cycle, valid_q<=1; the current output is squashed, and if_instr of the target appears on the next cycle.
REQ-020 Redirect together with stall SHALL be handled as a redirect; stall is ignored for that cycle.
REQ-021 if_instr SHALL be imem_instr when if_valid=1, else 32'h0 (nop).
REQ-022 if_valid SHALL equal valid_q in RUN and 0 in BOOT and HALT.
REQ-023 Address arithmetic SHALL be modulo 1024: pc 1023 increments to 0, and if_pc_plus1 of 1023 is 0.
REQ-024 fetch_count SHALL increment by 1 when if_valid=1, stall=0 and redirect=0, wrapping from 16'hFFFF to 0.
REQ-025 BOOT SHALL be the first cycle after rst falls: imem_addr=0, pc_q<=1, pc_d<=0, valid_q<=1, then go to RUN unconditionally (stall and redirect ignored).
REQ-026 RUN->HALT on halt=1, which wins over a simultaneous redirect or stall: pc_q and pc_d freeze, valid_q<=0.
REQ-027 HALT SHALL be left only by rst; redirect and stall are ignored there.

Reset
REQ-028 While rst=1 at a clk edge: pc_q=0, pc_d=0, valid_q=0, fetch_count=0, state=BOOT.
REQ-029 During reset the outputs SHALL be if_valid=0, if_instr=0, if_pc=0, if_pc_plus1=1 and imem_addr=0.
REQ-030 rst asserted mid-operation (including during a stall, redirect or HALT) SHALL override everything on that edge.

Structure
REQ-031 A shared package fetch_pkg SHALL hold ADDR_W=10, INSTR_W=32, NOP_INSTR=32'h0, CNT_W=16 and the fsm state encoding.
REQ-032 The block SHALL contain one sub-module, fetch_next_pc, a combinational priority mux implementing REQ-015 and REQ-016; the rest is flat.

Verification
REQ-033 Release rst with stall=0 and memory preloaded -> if_valid rises 2 cycles after rst falls, with if_pc 0,1,2,... on consecutive cycles and if_instr matching memory.
REQ-034 Stall for 3 cycles while if_pc=5 -> if_pc=5, if_instr=mem[5] and if_valid=1 held for 3 cycles; if_pc=6 appears the cycle after stall drops; fetch_count +1 only once.
REQ-035 Redirect to 25 while if_pc=19 -> next cycle if_pc=25 with if_instr=mem[25]; the squashed instruction is never counted.
REQ-036 Redirect and stall in the same cycle -> behaves as redirect only; target appears next cycle.
REQ-037 Redirect to 1023, run 2 cycles -> if_pc 1023 then 0, and if_pc_plus1 = 0 then 1.
REQ-038 Halt asserted while RUN -> if_valid=0 from the next cycle and pc frozen even if redirect pulses; rst restarts the BOOT sequence with fetch_count=0.
